// File: rtl/phy_rx_pkg.sv
// Shared receive-path definitions: byte width, the idle comma and the
// alignment FSM state encodings. The TX serialiser uses the same comma.
package phy_rx_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      ALIGN  = 2'b01,
      ACTIVE = 2'b10
   } rx_state_e;

endpackage

// File: rtl/serie_paralelo_sync_if.sv
// Serial-in / parallel-out bundle between the bit source and the byte aligner.
interface serie_paralelo_sync_if;
   import phy_rx_pkg::*;

   logic              data_inS;
   logic [BYTE_W-1:0] data_outP;
   logic              valid_out;
   logic              active;
   logic              byte_stb;

   modport master (
      output data_inS,
      input  data_outP,
      input  valid_out,
      input  active,
      input  byte_stb
   );

   modport slave (
      input  data_inS,
      output data_outP,
      output valid_out,
      output active,
      output byte_stb
   );

endinterface

// File: rtl/serie_paralelo_sync_shift_in8.sv
// Serial-in shift register; o_w is the byte ending with the bit sampled this edge.
module shift_in8
   import phy_rx_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_bit,
   output logic [BYTE_W-1:0] o_w
);

   // The bit shifted past the window MSB is never consulted again, so only
   // the seven most recent bits are kept as history.
   logic [BYTE_W-2:0] r_sr;

   assign o_w = {r_sr, i_bit};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr <= '0;
      end else begin
         r_sr <= o_w[BYTE_W-2:0];
      end
   end

endmodule

// File: rtl/serie_paralelo_sync.sv
// Receive byte aligner: locks onto repeated commas, then reassembles MSB-first bytes.
//
//  state  | meaning
//  HUNT   | sliding one bit at a time looking for a comma
//  ALIGN  | comma seen; counting byte-aligned commas towards lock
//  ACTIVE | locked; present one byte per 8-bit boundary (sticky until reset)
module serie_paralelo_sync
   import phy_rx_pkg::*;
#(
   parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
   parameter int                SYNC_COUNT = 4
)
(
   input  logic                  clk_8f,
   input  logic                  reset,
   serie_paralelo_sync_if.slave  bus
);

   localparam logic [2:0] SYNC_TGT = 3'(SYNC_COUNT);

   logic [BYTE_W-1:0] w_win;
   logic              w_is_comma;
   logic              w_boundary;
   logic [2:0]        w_comma_inc;

   rx_state_e         r_state,     w_state_nxt;
   logic [2:0]        r_bit_cnt,   w_bit_cnt_nxt;
   logic [2:0]        r_comma_cnt, w_comma_cnt_nxt;
   logic [BYTE_W-1:0] r_data,      w_data_nxt;
   logic              r_valid,     w_valid_nxt;
   logic              r_active,    w_active_nxt;
   logic              r_stb,       w_stb_nxt;

   shift_in8 u_shift (
      .i_clk   (clk_8f),
      .i_rst_n (reset),
      .i_bit   (bus.data_inS),
      .o_w     (w_win)
   );

   assign w_is_comma  = (w_win == COMMA);
   assign w_boundary  = (r_bit_cnt == 3'd7);
   assign w_comma_inc = r_comma_cnt + 3'd1;

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         r_state     <= HUNT;
         r_bit_cnt   <= '0;
         r_comma_cnt <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_active    <= 1'b0;
         r_stb       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_comma_cnt <= w_comma_cnt_nxt;
         r_data      <= w_data_nxt;
         r_valid     <= w_valid_nxt;
         r_active    <= w_active_nxt;
         r_stb       <= w_stb_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_comma_cnt_nxt = r_comma_cnt;
      w_data_nxt      = r_data;
      w_valid_nxt     = r_valid;
      w_active_nxt    = r_active;
      w_stb_nxt       = 1'b0;

      case (r_state)
         HUNT: begin
            w_bit_cnt_nxt   = '0;
            w_comma_cnt_nxt = '0;
            if (w_is_comma) begin
               w_comma_cnt_nxt = 3'd1;
               if (SYNC_TGT == 3'd1) begin
                  w_state_nxt  = ACTIVE;
                  w_active_nxt = 1'b1;
               end else begin
                  w_state_nxt  = ALIGN;
               end
            end
         end

         ALIGN: begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_boundary) begin
               if (w_is_comma) begin
                  w_comma_cnt_nxt = w_comma_inc;
                  if (w_comma_inc == SYNC_TGT) begin
                     w_state_nxt  = ACTIVE;
                     w_active_nxt = 1'b1;
                  end
               end else begin
                  // A broken comma run restarts the search on the next edge.
                  w_state_nxt     = HUNT;
                  w_comma_cnt_nxt = '0;
                  w_bit_cnt_nxt   = '0;
               end
            end
         end

         ACTIVE: begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (w_boundary) begin
               w_data_nxt  = w_win;
               w_valid_nxt = !w_is_comma;
               w_stb_nxt   = 1'b1;
            end
         end

         default: begin
            w_state_nxt     = HUNT;
            w_bit_cnt_nxt   = '0;
            w_comma_cnt_nxt = '0;
         end
      endcase
   end

   assign bus.data_outP = r_data;
   assign bus.valid_out = r_valid;
   assign bus.active    = r_active;
   assign bus.byte_stb  = r_stb;

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// Scoreboard bench for the byte aligner: directed serial streams, monitor pops on byte_stb.
module tb_serie_paralelo_sync;
   import phy_rx_pkg::*;

   logic clk_8f = 1'b0;
   logic reset  = 1'b1;

   serie_paralelo_sync_if bus();

   serie_paralelo_sync #(.COMMA(8'hBC), .SYNC_COUNT(4)) dut (
      .clk_8f (clk_8f),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_8f = ~clk_8f;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int last_stb = -1;
   logic [8:0] exp_q[$];

   always @(posedge clk_8f) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest pending byte and follow the previous by 8 cycles.
   always @(negedge clk_8f) begin
      logic [8:0] e;
      if (!reset) begin
         last_stb = -1;
      end else if (bus.byte_stb) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_stb: got byte %0h with nothing pending, expected no strobe", bus.data_outP);
         end else begin
            e = exp_q.pop_front();
            chk("data_outP", 32'(bus.data_outP), 32'(e[7:0]));
            chk("valid_out", 32'(bus.valid_out), 32'(e[8]));
         end
         chk("active_on_stb", 32'(bus.active), 32'd1);
         if (last_stb >= 0) chk("stb_period", 32'(cyc - last_stb), 32'd8);
         last_stb = cyc;
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk_8f);
      bus.data_inS = b;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit exp_out);
      if (exp_out) exp_q.push_back({(b != 8'hBC), b});
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic after_edge;
      @(posedge clk_8f);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"},   32'(bus.data_outP), 32'd0);
      chk({tag, "_valid"},  32'(bus.valid_out), 32'd0);
      chk({tag, "_active"}, 32'(bus.active),    32'd0);
      chk({tag, "_stb"},    32'(bus.byte_stb),  32'd0);
   endtask

   task automatic do_reset;
      @(negedge clk_8f);
      reset = 1'b0;
      bus.data_inS = 1'b0;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk_8f);
      reset = 1'b1;
   endtask

   task automatic lock4;
      repeat (3) send_byte(8'hBC, 1'b0);
      send_byte(8'hBC, 1'b0);
      chk("active_before_4th", 32'(bus.active), 32'd0);
      after_edge();
      chk("active_after_4th", 32'(bus.active), 32'd1);
   endtask

   task automatic drain(input string tag);
      repeat (2) @(negedge clk_8f);
      chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.data_inS = 1'b0;
      #1 reset = 1'b0;
      #1 check_zero("por");
      repeat (2) @(negedge clk_8f);
      reset = 1'b1;

      // 1: lock from clean reset, nothing presented yet
      lock4();
      chk("lock_valid", 32'(bus.valid_out), 32'd0);
      chk("lock_data",  32'(bus.data_outP), 32'd0);
      chk("lock_stb",   32'(bus.byte_stb),  32'd0);

      // 2: payload, including a trailing comma
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hAC, 1'b1);
      send_byte(8'hBC, 1'b1);
      drain("payload");

      // 3: misaligned start by three junk bits
      do_reset();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      lock4();
      send_byte(8'h55, 1'b1);
      drain("misaligned");

      // 4: broken comma run returns to hunt
      do_reset();
      send_byte(8'hBC, 1'b0);
      send_byte(8'hBC, 1'b0);
      send_byte(8'h55, 1'b0);
      after_edge();
      chk("broken_active", 32'(bus.active), 32'd0);
      lock4();
      send_byte(8'h5A, 1'b1);
      drain("broken");

      // 5: asynchronous reset in the middle of a payload byte
      do_reset();
      lock4();
      send_byte(8'hAA, 1'b1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      after_edge();
      #1 reset = 1'b0;
      #1 check_zero("midreset");
      repeat (2) @(negedge clk_8f);
      reset = 1'b1;
      lock4();
      send_byte(8'h77, 1'b1);
      drain("relock");

      // 6: stray comma inside payload keeps lock
      do_reset();
      lock4();
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBC, 1'b1);
      send_byte(8'hBB, 1'b1);
      after_edge();
      chk("stray_active", 32'(bus.active), 32'd1);
      drain("stray");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
